coreaxitoahbl_rd_byte_tracker: RTL and testbench

Parametrised read-burst byte tracker for the AXI-to-AHB-Lite bridge read path. It accepts one AXI INCR read command (address offset, length, size) and computes the burst's total valid byte count. It then steps through the data beats, presenting per-beat byte strobes, the beat byte count, the last-beat flag and a running byte count. It sits between the read address decode and the read data packer, and replaces fixed 64-bit, 16-beat lookup logic with arithmetic that covers any bus width, AXI3/AXI4 lengths and narrow transfers.

---
 rtl/coreaxitoahbl_rd_byte_tracker.sv | 140 ++++++++++++++
 tb/tb_coreaxitoahbl_rd_byte_tracker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coreaxitoahbl_rd_byte_tracker.sv
// Read-burst byte tracker for the AXI-to-AHB-Lite read path: takes one INCR read
// command, derives the burst byte total, then walks the beats with per-beat lane strobes.
module coreaxitoahbl_rd_byte_tracker #(
  parameter  int DATA_WIDTH = 64,
  parameter  int LEN_WIDTH  = 8,
  localparam int NBYTES     = DATA_WIDTH / 8,
  localparam int OFS_W      = $clog2(NBYTES),
  localparam int CNT_W      = OFS_W + LEN_WIDTH + 1
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OFS_W-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [2:0]           cmd_size,
  output logic                 size_err,
  output logic [CNT_W-1:0]     total_bytes,
  input  logic                 beat_valid,
  output logic [NBYTES-1:0]    beat_strb,
  output logic [OFS_W:0]       beat_bytes,
  output logic                 beat_last,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 done
);

  localparam int         OW1     = OFS_W + 1;
  localparam logic [2:0] MAX_ESZ = 3'(OFS_W);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [OFS_W-1:0]     ptr, ptr_next;
  logic [2:0]           esize, esize_next;
  logic [LEN_WIDTH-1:0] beats_left, beats_left_next;
  logic [CNT_W-1:0]     byte_count_next, total_next;
  logic                 size_err_next, done_next;

  // Command-side arithmetic: powers of two only, so every product is a shift.
  logic [2:0]       cmd_esize;
  logic [CNT_W-1:0] cmd_beat, cmd_lead, cmd_total;

  assign cmd_esize = (cmd_size > MAX_ESZ) ? MAX_ESZ : cmd_size;
  assign cmd_beat  = CNT_W'(1) << cmd_esize;
  assign cmd_lead  = cmd_beat - (CNT_W'(cmd_addr) & (cmd_beat - CNT_W'(1)));
  assign cmd_total = cmd_lead + (CNT_W'(cmd_len) << cmd_esize);

  // Beat geometry, one bit wider than the pointer so the window end can reach NBYTES.
  logic [OFS_W:0] beat_size, ptr_ext, aligned, beat_end, beat_span;

  assign beat_size = OW1'(1) << esize;
  assign ptr_ext   = {1'b0, ptr};
  assign aligned   = ptr_ext & ~(beat_size - OW1'(1));
  assign beat_end  = aligned + beat_size;
  assign beat_span = beat_end - ptr_ext;

  assign cmd_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      ptr         <= '0;
      esize       <= '0;
      beats_left  <= '0;
      byte_count  <= '0;
      total_bytes <= '0;
      size_err    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      esize       <= esize_next;
      beats_left  <= beats_left_next;
      byte_count  <= byte_count_next;
      total_bytes <= total_next;
      size_err    <= size_err_next;
      done        <= done_next;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    esize_next      = esize;
    beats_left_next = beats_left;
    byte_count_next = byte_count;
    total_next      = total_bytes;
    size_err_next   = size_err;
    done_next       = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          ptr_next        = cmd_addr;
          esize_next      = cmd_esize;
          beats_left_next = cmd_len;
          byte_count_next = '0;
          total_next      = cmd_total;
          size_err_next   = (cmd_size > MAX_ESZ);
          state_next      = ACTIVE;
        end
      end
      ACTIVE: begin
        if (beat_valid) begin
          byte_count_next = byte_count + CNT_W'(beat_span);
          // Dropping the top bit wraps the pointer to lane 0 at the bus boundary.
          ptr_next        = beat_end[OFS_W-1:0];
          if (beats_left == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            beats_left_next = beats_left - LEN_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    beat_strb  = '0;
    beat_bytes = '0;
    beat_last  = 1'b0;
    if (state == ACTIVE) begin
      beat_bytes = beat_span;
      beat_last  = (beats_left == '0);
      for (int i = 0; i < NBYTES; i++) begin
        beat_strb[i] = (OW1'(i) >= ptr_ext) && (OW1'(i) < beat_end);
      end
    end
  end

endmodule

// File: tb/tb_coreaxitoahbl_rd_byte_tracker.sv
// Self-checking bench for coreaxitoahbl_rd_byte_tracker on a 64-bit bus; expected beats
// come from AXI address arithmetic (beat start addresses), not from the lane-pointer walk.
module tb_coreaxitoahbl_rd_byte_tracker;

  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 8;
  localparam int NBYTES     = DATA_WIDTH / 8;
  localparam int OFS_W      = $clog2(NBYTES);
  localparam int CNT_W      = OFS_W + LEN_WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 areset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [OFS_W-1:0]     cmd_addr = '0;
  logic [LEN_WIDTH-1:0] cmd_len = '0;
  logic [2:0]           cmd_size = '0;
  logic                 size_err;
  logic [CNT_W-1:0]     total_bytes;
  logic                 beat_valid = 1'b0;
  logic [NBYTES-1:0]    beat_strb;
  logic [OFS_W:0]       beat_bytes;
  logic                 beat_last;
  logic [CNT_W-1:0]     byte_count;
  logic                 done;

  int checks = 0;
  int failures = 0;

  int obs_strb[$];
  int obs_bytes[$];
  int obs_total;
  int obs_size_err;

  always #5 clk = ~clk;

  coreaxitoahbl_rd_byte_tracker #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .ACLK(clk), .ARESET(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .size_err(size_err), .total_bytes(total_bytes),
    .beat_valid(beat_valid), .beat_strb(beat_strb), .beat_bytes(beat_bytes),
    .beat_last(beat_last), .byte_count(byte_count), .done(done)
  );

  // Reference model: beat k of an INCR burst starts at byte address
  // addr (k==0) or align(addr) + k*B, and occupies bytes up to the next B boundary.
  function automatic int eff_size(input int size);
    return (size > OFS_W) ? OFS_W : size;
  endfunction

  function automatic int exp_total(input int addr, input int len, input int size);
    int b;
    b = 1 << eff_size(size);
    return (b - (addr % b)) + len * b;
  endfunction

  function automatic int exp_bytes(input int addr, input int size, input int k);
    int b;
    b = 1 << eff_size(size);
    return (k == 0) ? (b - (addr % b)) : b;
  endfunction

  function automatic int exp_strb(input int addr, input int size, input int k);
    int b, start, lane, n, s;
    b     = 1 << eff_size(size);
    start = (k == 0) ? addr : ((addr / b) * b + k * b);
    lane  = start % NBYTES;
    n     = exp_bytes(addr, size, k);
    s     = 0;
    for (int i = 0; i < n; i++) s = s | (1 << (lane + i));
    return s;
  endfunction

  task automatic run_burst(input int addr, input int len, input int size,
                           input bit stall, input string name);
    int total_e, sum, w;
    obs_strb.delete();
    obs_bytes.delete();
    total_e = exp_total(addr, len, size);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr[OFS_W-1:0];
    cmd_len   = len[LEN_WIDTH-1:0];
    cmd_size  = size[2:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    obs_total    = int'(total_bytes);
    obs_size_err = int'(size_err);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: cmd_ready=%b required 0", name, cmd_ready);
    end
    checks++;
    if (total_bytes !== CNT_W'(total_e)) begin
      failures++;
      $display("FAIL %s_total: got %0d required %0d", name, total_bytes, total_e);
    end
    checks++;
    if (size_err !== (size > OFS_W)) begin
      failures++;
      $display("FAIL %s_size_err: got %b required %b", name, size_err, size > OFS_W);
    end
    sum = 0;
    for (int k = 0; k <= len; k++) begin
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      obs_strb.push_back(int'(beat_strb));
      obs_bytes.push_back(int'(beat_bytes));
      checks++;
      if (beat_strb !== NBYTES'(exp_strb(addr, size, k))) begin
        failures++;
        $display("FAIL %s_strb[%0d]: got %h required %h", name, k, beat_strb,
                 NBYTES'(exp_strb(addr, size, k)));
      end
      checks++;
      if (beat_bytes !== (OFS_W+1)'(exp_bytes(addr, size, k))) begin
        failures++;
        $display("FAIL %s_bytes[%0d]: got %0d required %0d", name, k, beat_bytes,
                 exp_bytes(addr, size, k));
      end
      checks++;
      if (beat_last !== (k == len)) begin
        failures++;
        $display("FAIL %s_last[%0d]: got %b required %b", name, k, beat_last, k == len);
      end
      checks++;
      if (byte_count !== CNT_W'(sum) || done !== 1'b0) begin
        failures++;
        $display("FAIL %s_progress[%0d]: byte_count=%0d done=%b required %0d/0",
                 name, k, byte_count, done, sum);
      end
      sum += exp_bytes(addr, size, k);
      beat_valid = 1'b1;
      @(negedge clk);
      beat_valid = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || byte_count !== CNT_W'(total_e) || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%b byte_count=%0d cmd_ready=%b required 1/%0d/1",
               name, done, byte_count, cmd_ready, total_e);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || beat_strb !== '0 || beat_bytes !== '0) begin
      failures++;
      $display("FAIL %s_after: done=%b strb=%h bytes=%0d required 0/0/0",
               name, done, beat_strb, beat_bytes);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || size_err !== 1'b0 || total_bytes !== '0 ||
        byte_count !== '0 || done !== 1'b0 || beat_strb !== '0 ||
        beat_bytes !== '0 || beat_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b err=%b total=%0d count=%0d done=%b strb=%h bytes=%0d last=%b",
               cmd_ready, size_err, total_bytes, byte_count, done, beat_strb, beat_bytes, beat_last);
    end
    beat_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (byte_count !== '0 || done !== 1'b0) begin
        failures++;
        $display("FAIL idle_beat_ignored: byte_count=%0d done=%b required 0/0", byte_count, done);
      end
    end
    beat_valid = 1'b0;
  endtask

  task automatic test_aligned();
    run_burst(0, 15, 3, 1'b0, "aligned");
    checks++;
    if (obs_total !== 128) begin
      failures++;
      $display("FAIL aligned_total_lit: got %0d required 128", obs_total);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs_strb[k] !== 32'hFF || obs_bytes[k] !== 8) begin
        failures++;
        $display("FAIL aligned_beat[%0d]: strb=%h bytes=%0d required ff/8", k, obs_strb[k], obs_bytes[k]);
      end
    end
  endtask

  task automatic test_unaligned();
    int es[4];
    int eb[4];
    es = '{32'hE0, 32'hFF, 32'hFF, 32'hFF};
    eb = '{3, 8, 8, 8};
    run_burst(5, 3, 3, 1'b1, "unaligned");
    checks++;
    if (obs_total !== 27) begin
      failures++;
      $display("FAIL unaligned_total_lit: got %0d required 27", obs_total);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_strb[k] !== es[k] || obs_bytes[k] !== eb[k]) begin
        failures++;
        $display("FAIL unaligned_beat[%0d]: strb=%h bytes=%0d required %h/%0d",
                 k, obs_strb[k], obs_bytes[k], es[k], eb[k]);
      end
    end
  endtask

  task automatic test_narrow_wrap();
    int es[5];
    int eb[5];
    es = '{32'h08, 32'h30, 32'hC0, 32'h03, 32'h0C};
    eb = '{1, 2, 2, 2, 2};
    run_burst(3, 4, 1, 1'b1, "narrow");
    checks++;
    if (obs_total !== 9) begin
      failures++;
      $display("FAIL narrow_total_lit: got %0d required 9", obs_total);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_strb[k] !== es[k] || obs_bytes[k] !== eb[k]) begin
        failures++;
        $display("FAIL narrow_beat[%0d]: strb=%h bytes=%0d required %h/%0d",
                 k, obs_strb[k], obs_bytes[k], es[k], eb[k]);
      end
    end
  endtask

  task automatic test_illegal_size();
    run_burst(0, 1, 4, 1'b0, "illegal");
    checks++;
    if (obs_size_err !== 1 || obs_total !== 16 || obs_strb[0] !== 32'hFF || obs_strb[1] !== 32'hFF) begin
      failures++;
      $display("FAIL illegal_lit: err=%0d total=%0d strb0=%h strb1=%h required 1/16/ff/ff",
               obs_size_err, obs_total, obs_strb[0], obs_strb[1]);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 8'd2; cmd_size = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    beat_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (beat_last !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_final_beat: last=%b ready=%b required 1/0", beat_last, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_addr = 3'd2; cmd_len = 8'd1; cmd_size = 3'd2;
    @(negedge clk);
    beat_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || byte_count !== CNT_W'(24)) begin
      failures++;
      $display("FAIL b2b_done_cycle: done=%b ready=%b count=%0d required 1/1/24", done, cmd_ready, byte_count);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || done !== 1'b0 || total_bytes !== CNT_W'(6) ||
        byte_count !== '0 || beat_strb !== 8'h0C || beat_bytes !== 4'd2) begin
      failures++;
      $display("FAIL b2b_accept: ready=%b done=%b total=%0d count=%0d strb=%h bytes=%0d required 0/0/6/0/0c/2",
               cmd_ready, done, total_bytes, byte_count, beat_strb, beat_bytes);
    end
    beat_valid = 1'b1;
    repeat (2) @(negedge clk);
    beat_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || byte_count !== CNT_W'(6)) begin
      failures++;
      $display("FAIL b2b_second_done: done=%b count=%0d required 1/6", done, byte_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 8'd15; cmd_size = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    beat_valid = 1'b1;
    repeat (2) @(negedge clk);
    beat_valid = 1'b0;
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || byte_count !== '0 || total_bytes !== '0 ||
        beat_strb !== '0 || beat_last !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: ready=%b count=%0d total=%0d strb=%h last=%b done=%b",
               cmd_ready, byte_count, total_bytes, beat_strb, beat_last, done);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL midreset_no_done: done=%b required 0", done);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_burst(int'($urandom_range(0, NBYTES - 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 4)), 1'b1, "random");
    end
    run_burst(7, 255, 3, 1'b0, "max_len");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_aligned();
    test_unaligned();
    test_narrow_wrap();
    test_illegal_size();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
